// File: rtl/serial_sub_pkg.sv
// ==================================================================
// Package : serial_sub_pkg  -- shared state type and default width
// Revision: 1.0
// ==================================================================
`default_nettype none

package serial_sub_pkg;

    localparam int SERIAL_SUB_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

endpackage

`default_nettype wire

// File: rtl/full_subtractor_bit.sv
// ==================================================================
// Module  : full_subtractor_bit  -- 1-bit combinational x - y - bin
// Revision: 1.0
// ==================================================================
`default_nettype none

module full_subtractor_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ==================================================================
// Module  : serial_subtractor  -- bit-serial a - b - bin, LSB first
// Option  : SERIAL_SUB_SIGNED_EN adds the signed-overflow output ovf
// Revision: 1.0
// ==================================================================
`default_nettype none

module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_SIGNED_EN
    ,
    output logic             ovf
`endif
);

    localparam int            CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    sub_state_t       r_state;
    sub_state_t       w_next;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             w_d;
    logic             w_br;
    logic             w_last;

    full_subtractor_bit u_fsb (
        .x    (r_opa[0]),
        .y    (r_opb[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_br)
    );

    assign w_last = (r_cnt == c_last);
    assign busy   = (r_state == SHIFT);
    assign done   = (r_state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // diff/bout/ovf load only on the final shift so partial results never show
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa <= '0;
            r_opb <= '0;
            r_res <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_opa <= a;
                        r_opb <= b;
                        r_br  <= bin;
                        r_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_opa <= r_opa >> 1;
                    r_opb <= r_opb >> 1;
                    r_res <= {w_d, r_res[WIDTH-1:1]};
                    r_br  <= w_br;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        diff <= {w_d, r_res[WIDTH-1:1]};
                        bout <= w_br;
`ifdef SERIAL_SUB_SIGNED_EN
                        // operand LSBs now hold the original MSBs
                        ovf  <= (r_opa[0] ^ r_opb[0]) & (r_opa[0] ^ w_d);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ==================================================================
// Module  : tb_serial_subtractor  -- randomized self-checking bench
// Revision: 1.0
// ==================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_SIGNED_EN
    logic         ovf;
`endif

    int n_total = 0;
    int n_pass  = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_SIGNED_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: ph counts cycles since acceptance (0 = idle)
    int           ph;
    logic [W-1:0] p_diff, m_diff;
    logic         p_bout, m_bout, p_ovf, m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph     <= 0;
            m_diff <= '0;
            m_bout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (ph == 0) begin
            if (start) begin
                ph     <= 1;
                p_diff <= W'(a - b - {{(W-1){1'b0}}, bin});
                p_bout <= (int'(a) < int'(b) + int'(bin));
                p_ovf  <= (a[W-1] ^ b[W-1]) &
                          (a[W-1] ^ W'(a - b - {{(W-1){1'b0}}, bin}) >> (W-1));
            end
        end else if (ph == W) begin
            ph     <= W + 1;
            m_diff <= p_diff;
            m_bout <= p_bout;
            m_ovf  <= p_ovf;
        end else if (ph == W + 1) begin
            ph <= 0;
        end else begin
            ph <= ph + 1;
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(ph >= 1 && ph <= W));
        chk("done", 32'(done), 32'(ph == W + 1));
        chk("diff", 32'(diff), 32'(m_diff));
        chk("bout", 32'(bout), 32'(m_bout));
`ifdef SERIAL_SUB_SIGNED_EN
        chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
    end

    // Drives one operation from idle; checks latency and the given literal results
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                         input logic [W-1:0] ed, input logic eb, input logic chk_ovf,
                         input logic eo);
        int cyc;
        int nbusy;
        bit seen;
        @(posedge clk); #1;
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; nbusy = 0; seen = 0;
        while (!seen && cyc < 40) begin
            if (busy) nbusy++;
            if (done) seen = 1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("op_done_seen", 32'(seen), 32'd1);
        chk("op_latency", 32'(cyc), 32'(W + 1));
        chk("op_busy_cycles", 32'(nbusy), 32'(W));
        chk("op_diff", 32'(diff), 32'(ed));
        chk("op_bout", 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_SIGNED_EN
        if (chk_ovf) chk("op_ovf", 32'(ovf), 32'(eo));
`else
        if (chk_ovf && eo) chk("op_ovf_unused", 32'(eo), 32'(eo ^ chk_ovf ^ 1'b1));
`endif
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("wait_done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        int c1;
        int c2;
        logic [W-1:0] ra, rb;
        logic         rbin;
        start = 1'b0; a = '0; b = '0; bin = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        do_op(8'd100, 8'd37, 1'b0, 8'd63,  1'b0, 1'b0, 1'b0);
        do_op(8'd5,   8'd10, 1'b0, 8'd251, 1'b1, 1'b0, 1'b0);
        do_op(8'd0,   8'd0,  1'b1, 8'd255, 1'b1, 1'b0, 1'b0);
        do_op(8'd0,   8'd0,  1'b0, 8'd0,   1'b0, 1'b0, 1'b0);
        do_op(8'hFF,  8'h00, 1'b0, 8'hFF,  1'b0, 1'b0, 1'b0);
`ifdef SERIAL_SUB_SIGNED_EN
        do_op(8'h80,  8'h01, 1'b0, 8'h7F,  1'b0, 1'b1, 1'b1);
        do_op(8'h7F,  8'hFF, 1'b0, 8'h80,  1'b1, 1'b1, 1'b1);
        do_op(8'h10,  8'h05, 1'b0, 8'h0B,  1'b0, 1'b1, 1'b0);
`endif

        // start held high through busy: second op only on IDLE re-entry
        @(posedge clk); #1;
        a = 8'd9; b = 8'd4; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 8'd1; b = 8'd2;
        wait_done(c1);
        chk("hold_first_diff", 32'(diff), 32'd5);
        chk("hold_first_bout", 32'(bout), 32'd0);
        @(posedge clk); #1;
        chk("hold_idle_busy", 32'(busy), 32'd0);
        chk("hold_idle_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        wait_done(c2);
        chk("hold_gap", 32'(c2 + 2), 32'(W + 2));
        chk("hold_second_diff", 32'(diff), 32'd255);
        chk("hold_second_bout", 32'(bout), 32'd1);
        start = 1'b0;
        @(posedge clk); #1;

        // reset mid-operation
        @(posedge clk); #1;
        a = 8'd100; b = 8'd37; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_op(8'd200, 8'd55, 1'b1, 8'd144, 1'b0, 1'b0, 1'b0);

        // randomized back-to-back operations with literal-free arithmetic expectations
        for (int i = 0; i < 120; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            do_op(ra, rb, rbin, W'(ra - rb - {{(W-1){1'b0}}, rbin}),
                  (int'(ra) < int'(rb) + int'(rbin)), 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // free-running random start/operands; per-cycle compare does the checking
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 3) != 0);
            a     = W'($urandom);
            b     = W'($urandom);
            bin   = 1'($urandom);
        end
        start = 1'b0;
        repeat (W + 4) @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
